register_bank: RTL

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank_if.sv | 32 +++
 rtl/register_bank.sv | 76 +++++++
 2 files changed

// File: rtl/register_bank_if.sv
// Write-back, operand read and issue signals between decode/execute and the register bank.
interface register_bank_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      w_reg_en_in;
    logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in;
    logic [DATA_WIDTH-1:0]     reg_data_in;
    logic                      rd_en_a_in;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_a_in;
    logic                      rd_en_b_in;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_b_in;
    logic                      issue_en_in;
    logic [REG_ADDR_WIDTH-1:0] issue_addr_in;
    logic [DATA_WIDTH-1:0]     rd_data_a_out;
    logic [DATA_WIDTH-1:0]     rd_data_b_out;
    logic                      stall_out;

    modport master (
        output w_reg_en_in, w_reg_addr_in, reg_data_in,
        output rd_en_a_in, rd_addr_a_in, rd_en_b_in, rd_addr_b_in,
        output issue_en_in, issue_addr_in,
        input  rd_data_a_out, rd_data_b_out, stall_out
    );

    modport slave (
        input  w_reg_en_in, w_reg_addr_in, reg_data_in,
        input  rd_en_a_in, rd_addr_a_in, rd_en_b_in, rd_addr_b_in,
        input  issue_en_in, issue_addr_in,
        output rd_data_a_out, rd_data_b_out, stall_out
    );
endinterface

// File: rtl/register_bank.sv
// Two-read/one-write register file with write-through bypass and a per-register pending scoreboard.
// Latency: reads and stall are combinational; writes and pending updates land on the rising edge.
// Backpressure: stall_out holds decode while an enabled operand is pending; issues seen under stall are dropped.
module register_bank #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    register_bank_if.slave   bus
);
    localparam int NREGS = 1 << REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0]      pending;
    logic [NREGS-1:0]      set_vec;
    logic [NREGS-1:0]      clr_vec;
    logic                  wb_vld;
    logic                  issue_ok;
    logic                  stall_a;
    logic                  stall_b;
    logic                  stall;

    // Write-back is inert while reset is held, so nothing bypasses or lands during reset.
    assign wb_vld = rst_n && bus.w_reg_en_in && (bus.w_reg_addr_in != '0);

    function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [REG_ADDR_WIDTH-1:0] addr);
        if (addr == '0)
            return '0;
        else if (wb_vld && (addr == bus.w_reg_addr_in))
            return bus.reg_data_in;
        else
            return regs[addr];
    endfunction

    always_comb begin
        bus.rd_data_a_out = read_reg(bus.rd_addr_a_in);
        bus.rd_data_b_out = read_reg(bus.rd_addr_b_in);
    end

    // A same-cycle write-back to the operand resolves the hazard through the bypass.
    assign stall_a = bus.rd_en_a_in && pending[bus.rd_addr_a_in] &&
                     !(wb_vld && (bus.rd_addr_a_in == bus.w_reg_addr_in));
    assign stall_b = bus.rd_en_b_in && pending[bus.rd_addr_b_in] &&
                     !(wb_vld && (bus.rd_addr_b_in == bus.w_reg_addr_in));
    assign stall   = stall_a || stall_b;
    assign bus.stall_out = stall;

    assign issue_ok = rst_n && bus.issue_en_in && (bus.issue_addr_in != '0) && !stall;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_ok)
            set_vec[bus.issue_addr_in] = 1'b1;
        if (wb_vld)
            clr_vec[bus.w_reg_addr_in] = 1'b1;
    end

    // Set wins over clear when issue and write-back hit the same register on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= (pending & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb_vld) begin
            regs[bus.w_reg_addr_in] <= bus.reg_data_in;
        end
    end
endmodule
